// File: rtl/wt_dcache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : wt_dcache_mem_responder
// Brief    : Single-outstanding bridge from dcache load/store requests to a
//            64-bit backing memory; assembles refill lines and acks stores.
// Revision : 1.0
// ============================================================================
module wt_dcache_mem_responder #(
   parameter int unsigned PLEN      = 56,
   parameter int unsigned LineWidth = 128,
   parameter int unsigned IdWidth   = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_vld_i,
   output logic                 req_ack_o,
   input  logic                 req_we_i,
   input  logic                 req_nc_i,
   input  logic [2:0]           req_size_i,
   input  logic [PLEN-1:0]      req_paddr_i,
   input  logic [63:0]          req_data_i,
   input  logic [IdWidth-1:0]   req_tid_i,
   output logic                 rtrn_vld_o,
   output logic                 rtrn_type_o,
   output logic [LineWidth-1:0] rtrn_data_o,
   output logic [IdWidth-1:0]   rtrn_tid_o,
   output logic                 mem_req_o,
   input  logic                 mem_gnt_i,
   output logic                 mem_we_o,
   output logic [PLEN-1:0]      mem_addr_o,
   output logic [63:0]          mem_wdata_o,
   output logic [7:0]           mem_be_o,
   input  logic                 mem_rvalid_i,
   input  logic [63:0]          mem_rdata_i
);

   localparam int unsigned NUM_BEATS = LineWidth / 64;
   localparam int unsigned BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int unsigned LINE_OFF  = $clog2(LineWidth / 8);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      WR_REQ  = 3'd3,
      WR_WAIT = 3'd4,
      RESP    = 3'd5
   } state_e;

   state_e               r_state;
   state_e               w_state_next;
   logic                 r_we;
   logic                 r_nc;
   logic [2:0]           r_size;
   logic [PLEN-1:0]      r_paddr;
   logic [63:0]          r_wdata;
   logic [IdWidth-1:0]   r_tid;
   logic [BEAT_W-1:0]    r_beat;
   logic [LineWidth-1:0] r_line;
   logic [LineWidth-1:0] r_rtrn_data;

   logic                 w_accept;
   logic                 w_last_beat;
   logic                 w_rd_beat;
   logic [PLEN-1:0]      w_word_addr;
   logic [PLEN-1:0]      w_line_addr;
   logic [7:0]           w_be_base;
   logic [7:0]           w_be;
   logic [LineWidth-1:0] w_line_next;

   assign w_accept    = req_vld_i & (r_state == IDLE);
   // Ack is gated by reset so it reads 0 while rst_ni is held low.
   assign req_ack_o   = w_accept & rst_ni;
   assign w_last_beat = r_nc | (r_beat == BEAT_W'(NUM_BEATS - 1));
   assign w_rd_beat   = (r_state == RD_WAIT) & mem_rvalid_i;
   assign w_word_addr = {r_paddr[PLEN-1:3], 3'b000};
   assign w_line_addr = {r_paddr[PLEN-1:LINE_OFF], {LINE_OFF{1'b0}}} + (PLEN'(r_beat) << 3);

   // Sizes above 3 saturate to a full doubleword.
   always_comb begin
      w_be_base = 8'hFF;
      if (!r_size[2]) begin
         case (r_size[1:0])
            2'd0:    w_be_base = 8'h01;
            2'd1:    w_be_base = 8'h03;
            2'd2:    w_be_base = 8'h0F;
            default: w_be_base = 8'hFF;
         endcase
      end
      w_be = w_be_base << r_paddr[2:0];
   end

   always_comb begin
      w_line_next = r_line;
      if (r_nc) begin
         w_line_next = {NUM_BEATS{mem_rdata_i}};
      end else begin
         w_line_next[r_beat*64 +: 64] = mem_rdata_i;
      end
   end

   always_comb begin
      w_state_next = r_state;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      mem_be_o     = '0;
      rtrn_vld_o   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_next = req_we_i ? WR_REQ : RD_REQ;
         end
         RD_REQ: begin
            mem_req_o  = 1'b1;
            mem_addr_o = r_nc ? w_word_addr : w_line_addr;
            if (mem_gnt_i) w_state_next = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_rvalid_i) w_state_next = w_last_beat ? RESP : RD_REQ;
         end
         WR_REQ: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = w_word_addr;
            mem_wdata_o = r_wdata;
            mem_be_o    = w_be;
            if (mem_gnt_i) w_state_next = WR_WAIT;
         end
         WR_WAIT: begin
            if (mem_rvalid_i) w_state_next = RESP;
         end
         RESP: begin
            rtrn_vld_o   = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_we    <= 1'b0;
         r_nc    <= 1'b0;
         r_size  <= '0;
         r_paddr <= '0;
         r_wdata <= '0;
         r_tid   <= '0;
      end else if (w_accept) begin
         r_we    <= req_we_i;
         r_nc    <= req_nc_i;
         r_size  <= req_size_i;
         r_paddr <= req_paddr_i;
         r_wdata <= req_data_i;
         r_tid   <= req_tid_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_beat <= '0;
      end else if (w_accept) begin
         r_beat <= '0;
      end else if (w_rd_beat && !w_last_beat) begin
         r_beat <= r_beat + BEAT_W'(1);
      end
   end

   // Beats assemble in r_line; the visible data only changes on entry to RESP.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_line      <= '0;
         r_rtrn_data <= '0;
      end else if (w_rd_beat) begin
         r_line <= w_line_next;
         if (w_last_beat) r_rtrn_data <= w_line_next;
      end
   end

   assign rtrn_data_o = r_rtrn_data;
   assign rtrn_type_o = r_we;
   assign rtrn_tid_o  = r_tid;

endmodule
`default_nettype wire

// File: tb/tb_wt_dcache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_wt_dcache_mem_responder
// Brief    : Directed + randomized bench with a word-level reference memory.
// Revision : 1.0
// ============================================================================
module tb_wt_dcache_mem_responder;

   localparam int PLEN = 56;
   localparam int LW   = 128;
   localparam int IDW  = 4;
   localparam int NB   = LW / 64;

   typedef struct packed {
      logic            we;
      logic [PLEN-1:0] addr;
      logic [63:0]     wdata;
      logic [7:0]      be;
   } cmd_t;

   logic            clk, rst_ni;
   logic            req_vld, req_we, req_nc;
   logic [2:0]      req_size;
   logic [PLEN-1:0] req_paddr;
   logic [63:0]     req_data;
   logic [IDW-1:0]  req_tid;
   logic            req_ack_o, rtrn_vld_o, rtrn_type_o;
   logic [LW-1:0]   rtrn_data_o;
   logic [IDW-1:0]  rtrn_tid_o;
   logic            mem_req_o, mem_we_o;
   logic [PLEN-1:0] mem_addr_o;
   logic [63:0]     mem_wdata_o;
   logic [7:0]      mem_be_o;
   logic            rsp_gnt, rsp_rvalid, spur_rvalid;
   logic [63:0]     rsp_rdata, spur_rdata;
   logic            mem_rvalid;
   logic [63:0]     mem_rdata;

   assign mem_rvalid = rsp_rvalid | spur_rvalid;
   assign mem_rdata  = spur_rvalid ? spur_rdata : rsp_rdata;

   int          n_assert, n_fail, gnt_cnt, gnt_override, rd_override;
   bit          zero_wait;
   cmd_t        exp_cmd[$];
   logic [63:0] bmem[logic [PLEN-1:0]];
   logic [63:0] rmem[logic [PLEN-1:0]];
   logic [LW-1:0] last_data;

   wt_dcache_mem_responder #(.PLEN(PLEN), .LineWidth(LW), .IdWidth(IDW)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_vld_i(req_vld), .req_ack_o(req_ack_o), .req_we_i(req_we), .req_nc_i(req_nc),
      .req_size_i(req_size), .req_paddr_i(req_paddr), .req_data_i(req_data), .req_tid_i(req_tid),
      .rtrn_vld_o(rtrn_vld_o), .rtrn_type_o(rtrn_type_o), .rtrn_data_o(rtrn_data_o), .rtrn_tid_o(rtrn_tid_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(rsp_gnt), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] init_word(input logic [PLEN-1:0] a);
      return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
   endfunction

   function automatic logic [63:0] bread(input logic [PLEN-1:0] a);
      return bmem.exists(a) ? bmem[a] : init_word(a);
   endfunction

   function automatic logic [63:0] rread(input logic [PLEN-1:0] a);
      return rmem.exists(a) ? rmem[a] : init_word(a);
   endfunction

   // Enabled bytes: 2**min(size,3) consecutive bytes starting at the offset, clipped at byte 7.
   function automatic logic [7:0] ref_be(input logic [2:0] size, input logic [2:0] off);
      int nbytes;
      logic [7:0] m;
      nbytes = 1 << ((size > 3'd3) ? 3 : int'(size));
      m = '0;
      for (int i = 0; i < 8; i++)
         if (i >= int'(off) && i < int'(off) + nbytes) m[i] = 1'b1;
      return m;
   endfunction

   // Backing memory: grants, returns one completion per grant, checks every issued command.
   task automatic responder();
      int gw = 0;
      int pc = 0;
      bit pv = 0;
      logic [63:0] pd = '0;
      logic [63:0] w;
      cmd_t c;
      forever begin
         @(negedge clk);
         rsp_gnt = 1'b0;
         rsp_rvalid = 1'b0;
         if (!rst_ni) begin
            pv = 0;
            gw = 0;
            continue;
         end
         if (pv) begin
            chk("mem_req_in_wait", LW'(mem_req_o), LW'(1'b0));
            if (pc == 0) begin
               rsp_rvalid = 1'b1;
               rsp_rdata  = pd;
               pv = 0;
            end else pc--;
         end else if (mem_req_o) begin
            if (gnt_override >= 0) begin
               gw = gnt_override;
               gnt_override = -1;
            end
            chk("cmd_expected", LW'(exp_cmd.size() != 0), LW'(1'b1));
            if (exp_cmd.size() != 0) begin
               c = exp_cmd[0];
               chk("mem_we", LW'(mem_we_o), LW'(c.we));
               chk("mem_addr", LW'(mem_addr_o), LW'(c.addr));
               if (c.we) begin
                  chk("mem_wdata", LW'(mem_wdata_o), LW'(c.wdata));
                  chk("mem_be", LW'(mem_be_o), LW'(c.be));
               end
               if (gw == 0) begin
                  rsp_gnt = 1'b1;
                  gnt_cnt++;
                  void'(exp_cmd.pop_front());
                  if (mem_we_o) begin
                     w = bread(mem_addr_o);
                     for (int i = 0; i < 8; i++)
                        if (mem_be_o[i]) w[i*8 +: 8] = mem_wdata_o[i*8 +: 8];
                     bmem[mem_addr_o] = w;
                     pd = {$urandom, $urandom};
                  end else begin
                     pd = bread(mem_addr_o);
                  end
                  pv = 1;
                  pc = ((rd_override > 0) ? rd_override : (zero_wait ? 1 : int'($urandom_range(1, 3)))) - 1;
                  rd_override = 0;
                  gw = zero_wait ? 0 : int'($urandom_range(0, 3));
               end else gw--;
            end
         end
      end
   endtask

   task automatic do_req(input bit we, input bit nc, input logic [2:0] size, input logic [PLEN-1:0] pa,
                         input logic [63:0] d, input logic [IDW-1:0] tid, input int exp_lat, input bit hold);
      logic [LW-1:0]   exp_data;
      logic [PLEN-1:0] wa, la;
      logic [63:0]     w;
      logic [7:0]      be;
      int              lat;
      bit              seen;
      wa = pa & ~PLEN'(7);
      la = pa & ~PLEN'(LW / 8 - 1);
      exp_data = last_data;
      if (we) begin
         be = ref_be(size, pa[2:0]);
         exp_cmd.push_back('{1'b1, wa, d, be});
         w = rread(wa);
         for (int i = 0; i < 8; i++) if (be[i]) w[i*8 +: 8] = d[i*8 +: 8];
         rmem[wa] = w;
      end else if (nc) begin
         exp_cmd.push_back('{1'b0, wa, 64'h0, 8'h0});
         for (int k = 0; k < NB; k++) exp_data[k*64 +: 64] = rread(wa);
      end else begin
         for (int k = 0; k < NB; k++) begin
            exp_cmd.push_back('{1'b0, la + PLEN'(8 * k), 64'h0, 8'h0});
            exp_data[k*64 +: 64] = rread(la + PLEN'(8 * k));
         end
      end
      @(posedge clk); #1;
      req_vld = 1'b1; req_we = we; req_nc = nc; req_size = size;
      req_paddr = pa; req_data = d; req_tid = tid;
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (req_ack_o) seen = 1;
      end
      chk("ack_seen", LW'(seen), LW'(1'b1));
      if (!seen) begin
         req_vld = 1'b0;
         return;
      end
      @(posedge clk); #1;
      if (!hold) req_vld = 1'b0;
      lat = 0;
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (rtrn_vld_o) seen = 1;
         else begin
            chk("data_hold", rtrn_data_o, last_data);
            if (hold) chk("no_ack_busy", LW'(req_ack_o), LW'(1'b0));
         end
      end
      chk("rtrn_seen", LW'(seen), LW'(1'b1));
      if (!seen) begin
         req_vld = 1'b0;
         return;
      end
      if (hold) begin
         chk("no_ack_resp", LW'(req_ack_o), LW'(1'b0));
         req_vld = 1'b0;
      end
      chk("rtrn_type", LW'(rtrn_type_o), LW'(we));
      chk("rtrn_tid", LW'(rtrn_tid_o), LW'(tid));
      chk("rtrn_data", rtrn_data_o, exp_data);
      if (exp_lat > 0) chk("latency", LW'(lat), LW'(exp_lat));
      last_data = exp_data;
      @(negedge clk);
      chk("vld_one_cycle", LW'(rtrn_vld_o), LW'(1'b0));
      chk("data_after", rtrn_data_o, last_data);
   endtask

   initial begin
      int g0;
      bit got;
      n_assert = 0; n_fail = 0; gnt_cnt = 0; gnt_override = -1; rd_override = 0;
      zero_wait = 1; last_data = '0;
      rsp_gnt = 0; rsp_rvalid = 0; rsp_rdata = '0; spur_rvalid = 0; spur_rdata = '0;
      rst_ni = 0; req_vld = 1; req_we = 0; req_nc = 0; req_size = 3'd3;
      req_paddr = 56'h1000; req_data = '0; req_tid = '0;
      fork responder(); join_none

      #3;
      chk("rst_ack", LW'(req_ack_o), LW'(1'b0));
      chk("rst_vld", LW'(rtrn_vld_o), LW'(1'b0));
      chk("rst_memreq", LW'(mem_req_o), LW'(1'b0));
      chk("rst_data", rtrn_data_o, '0);
      chk("rst_be", LW'(mem_be_o), LW'(8'h0));
      repeat (3) @(negedge clk);
      rst_ni = 1; req_vld = 0;

      bmem[56'h1000] = 64'hA; rmem[56'h1000] = 64'hA;
      bmem[56'h1008] = 64'hB; rmem[56'h1008] = 64'hB;
      bmem[56'h2000] = 64'h55; rmem[56'h2000] = 64'h55;

      do_req(0, 0, 3'd3, 56'h1008, 64'h0, 4'd1, 5, 0);
      chk("line_literal", rtrn_data_o, {64'hB, 64'hA});
      do_req(0, 1, 3'd3, 56'h2004, 64'h0, 4'd2, 3, 0);
      chk("nc_literal", rtrn_data_o, {64'h55, 64'h55});
      do_req(1, 0, 3'd1, 56'h3006, 64'h1234_5678_9ABC_DEF0, 4'd3, 3, 0);

      // Completions arriving while idle must be dropped.
      @(posedge clk); #1;
      spur_rvalid = 1; spur_rdata = 64'hDEAD_BEEF_0BAD_F00D;
      @(negedge clk);
      chk("spur_vld0", LW'(rtrn_vld_o), LW'(1'b0));
      @(posedge clk); #1;
      spur_rvalid = 0;
      @(negedge clk);
      chk("spur_vld1", LW'(rtrn_vld_o), LW'(1'b0));
      chk("spur_memreq", LW'(mem_req_o), LW'(1'b0));
      chk("spur_data", rtrn_data_o, last_data);

      gnt_override = 4;
      do_req(1, 0, 3'd2, 56'h3010, 64'hCAFE_F00D_1111_2222, 4'd5, 7, 1);
      do_req(1, 0, 3'd7, 56'h3018, 64'h0102_0304_0506_0708, 4'd6, 3, 0);
      do_req(0, 1, 3'd0, 56'h3004, 64'h0, 4'd7, 3, 0);
      do_req(0, 0, 3'd0, 56'h3010, 64'h0, 4'd8, 5, 0);

      zero_wait = 0;
      for (int n = 0; n < 40; n++) begin
         do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                PLEN'(32'h4000 + $urandom_range(0, 255)), {$urandom, $urandom},
                IDW'($urandom_range(0, 15)), 0, 0);
      end

      // Abort a load while waiting for its completion.
      rd_override = 3;
      exp_cmd.push_back('{1'b0, 56'h5000, 64'h0, 8'h0});
      @(posedge clk); #1;
      req_vld = 1; req_we = 0; req_nc = 1; req_size = 3'd3; req_paddr = 56'h5000; req_tid = 4'd9;
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (req_ack_o) got = 1;
      end
      chk("abort_ack", LW'(got), LW'(1'b1));
      @(posedge clk); #1;
      req_vld = 0;
      g0 = gnt_cnt;
      for (int i = 0; i < 50 && gnt_cnt == g0; i++) begin
         @(posedge clk); #1;
      end
      chk("abort_granted", LW'(gnt_cnt != g0), LW'(1'b1));
      req_vld = 1; req_nc = 0; req_paddr = 56'h6000;
      rst_ni = 0;
      #1;
      chk("arst_memreq", LW'(mem_req_o), LW'(1'b0));
      chk("arst_ack", LW'(req_ack_o), LW'(1'b0));
      chk("arst_vld", LW'(rtrn_vld_o), LW'(1'b0));
      chk("arst_data", rtrn_data_o, '0);
      chk("arst_tid", LW'(rtrn_tid_o), LW'(4'd0));
      chk("arst_type", LW'(rtrn_type_o), LW'(1'b0));
      chk("arst_we", LW'(mem_we_o), LW'(1'b0));
      chk("arst_addr", LW'(mem_addr_o), LW'(56'h0));
      chk("arst_be", LW'(mem_be_o), LW'(8'h0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("arst_novld", LW'(rtrn_vld_o), LW'(1'b0));
      end
      rst_ni = 1; req_vld = 0;
      exp_cmd.delete();
      last_data = '0;
      rd_override = 0;
      zero_wait = 1;
      do_req(0, 0, 3'd3, 56'h1000, 64'h0, 4'd4, 5, 0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wt_dcache_mem_responder.md
WT_DCACHE_MEM_RESPONDER -- requirements
Module: wt_dcache_mem_responder

Interface
REQ-001 Param PLEN, default riscv::PLEN, physical address width.
REQ-002 Param LineWidth, default DCACHE_LINE_WIDTH (128), refill line width; SHALL be a multiple of 64.
REQ-003 Param IdWidth, default CACHE_ID_WIDTH, transaction ID width.
REQ-004 Port clk_i  in  1  clock; single clock domain.
REQ-005 Port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 Port req_vld_i  in  1  dcache request valid.
REQ-007 Port req_ack_o  out  1  request accepted this cycle.
REQ-008 Port req_we_i  in  1  0 = load, 1 = store.
REQ-009 Port req_nc_i  in  1  non-cacheable.
REQ-010 Port req_size_i  in  3  log2 byte size, 0..3.
REQ-011 Port req_paddr_i  in  PLEN  byte address.
REQ-012 Port req_data_i  in  64  store data, already lane-aligned.
REQ-013 Port req_tid_i  in  IdWidth  transaction ID.
REQ-014 Port rtrn_vld_o  out  1  response pulse; no backpressure.
REQ-015 Port rtrn_type_o  out  1  0 = load ack, 1 = store ack.
REQ-016 Port rtrn_data_o  out  LineWidth  load data.
REQ-017 Port rtrn_tid_o  out  IdWidth  echoed ID.
REQ-018 Port mem_req_o / mem_gnt_i  out/in  1/1  backing-memory request handshake.
REQ-019 Port mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  out  1, PLEN, 64, 8  backing-memory command; addr 8-byte aligned.
REQ-020 Port mem_rvalid_i, mem_rdata_i  in  1, 64  backing-memory completion, >=1 cycle after gnt, one per granted request.

Function
REQ-021 FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP; at most one transaction in flight.
REQ-022 req_ack_o = req_vld_i & (state==IDLE), combinational; on ack, capture we, nc, size, paddr, data, tid; go to RD_REQ (load) or WR_REQ (store).
REQ-023 Beat counter: cacheable load = LineWidth/64 beats; nc load = 1 beat; store = 1 beat.
REQ-024 RD_REQ: mem_req_o=1, mem_we_o=0; cacheable addr = line-aligned paddr + 8*beat; nc addr = paddr with [2:0] cleared; hold all mem_* outputs stable until mem_gnt_i; on gnt go to RD_WAIT.
REQ-025 RD_WAIT: on mem_rvalid_i, cacheable writes mem_rdata_i into rtrn_data_o lane [beat]; nc replicates mem_rdata_i into all lanes; last beat -> RESP, else beat+1 -> RD_REQ.
REQ-026 WR_REQ: mem_req_o=1, mem_we_o=1, addr = paddr with [2:0] cleared, wdata = captured data, be = ((1<<(1<<size))-1) << paddr[2:0], truncated to 8 bits; on gnt go to WR_WAIT.
REQ-027 WR_WAIT: on mem_rvalid_i go to RESP; mem_rdata_i ignored.
REQ-028 RESP: rtrn_vld_o=1 for exactly one cycle with rtrn_type_o=we, rtrn_tid_o=captured tid; next state IDLE; a new request SHALL NOT be acked in RESP.
REQ-029 mem_req_o SHALL be 0 in IDLE, RD_WAIT, WR_WAIT, RESP.
REQ-030 rtrn_data_o SHALL hold its value outside RESP; store responses leave it unchanged.
REQ-031 Latency, zero-wait memory (gnt same cycle, rvalid next cycle), accept at T: cacheable load (2 beats) rtrn_vld_o at T+5; nc load T+3; store T+3.
REQ-032 mem_rvalid_i outside RD_WAIT/WR_WAIT SHALL be ignored.
REQ-033 size>3 SHALL be treated as size 3.

Reset
REQ-034 On rst_ni low, asynchronously: state=IDLE, beat=0, all outputs 0 (req_ack_o, rtrn_vld_o, mem_req_o, mem_we_o, rtrn_data_o, rtrn_tid_o, mem_be_o etc.).
REQ-035 Reset mid-transaction SHALL abort it with no response; mem_req_o drops in the same cycle as reset assertion.

Verification
REQ-036 Cacheable load paddr 0x1008, tid 1, zero-wait memory returning 0xA then 0xB -> mem addrs 0x1000, 0x1008; rtrn_vld_o at T+5, data {0xB,0xA}, type 0, tid 1.
REQ-037 nc load paddr 0x2004, memory returns 0x55 -> single mem access at 0x2000; rtrn_data_o = {0x55,0x55}; rtrn_vld_o at T+3.
REQ-038 Store size 1, paddr 0x3006 -> mem_we_o=1, addr 0x3000, be 0xC0; store ack at T+3, tid echoed.
REQ-039 gnt withheld 4 cycles on store -> mem_req_o and address/data/be stable throughout; req_vld_i held high -> req_ack_o stays 0 until IDLE.
REQ-040 Back-to-back requests with random gnt/rvalid delays vs. reference memory model -> one response per ack, in order, correct data and IDs.
REQ-041 rst_ni asserted during RD_WAIT -> outputs 0 immediately, no rtrn_vld_o; first request after reset completes normally.
